axis_reduce_alu: RTL and testbench
==================================

Name: axis_reduce_alu

Overview:
- Parametrised successor to the two-operand stream adder used as a NoC endpoint.
- Accepts a variable-length operand packet on an AXI-Stream slave and reduces it with an operation selected per packet (add, subtract, unsigned max, unsigned min).
- Emits one single-beat result packet on an AXI-Stream master toward a configurable NoC destination.
- Packets are delimited by TLAST or by a maximum operand count, with optional saturation.

Parameters:
TDATAW, 32, operand/result data width
TDESTW, 4, NoC destination field width
TIDW, 2, ID width; TID[1:0] of first beat selects op (TIDW >= 2)
MAX_OPS, 8, max operands per packet (>= 1); forced packet end when reached
RESULT_DEST, 4'h1, TDEST driven on every result beat
SAT_EN, 0, 1 = saturate add/sub to all-ones/zero; 0 = modulo 2^TDATAW wrap

Ports:
CLK  input  1  clock, all logic on posedge
RST_N  input  1  asynchronous active-low reset
AXIS_S_TVALID  input  1  operand beat valid
AXIS_S_TREADY  output  1  block can accept operand
AXIS_S_TDATA  input  TDATAW  operand, unsigned
AXIS_S_TLAST  input  1  last operand of packet
AXIS_S_TID  input  TIDW  op select on first beat: 0 add, 1 sub, 2 max, 3 min
AXIS_S_TDEST  input  TDESTW  ignored
AXIS_M_TVALID  output  1  result valid
AXIS_M_TREADY  input  1  downstream ready
AXIS_M_TDATA  output  TDATAW  reduction result
AXIS_M_TLAST  output  1  always 1 while TVALID
AXIS_M_TID  output  TIDW  TID latched from first operand beat
AXIS_M_TDEST  output  TDESTW  RESULT_DEST while TVALID, else 0

Behaviour:
- Clock and reset:
  - One clock domain.
  - RST_N low asynchronously forces state IDLE; accumulator, op, count and latched TID go to 0.
  - Reset values: AXIS_M_TVALID=0, AXIS_M_TDATA=0, AXIS_M_TLAST=0, AXIS_M_TID=0, AXIS_M_TDEST=0, AXIS_S_TREADY=0.
  - Reset mid-packet or mid-send discards all work; there is no partial result.
- All datapath state is registered; no latches; combinational outputs are decoded from registered state only.
- Beat acceptance: an operand is accepted when S_TVALID & S_TREADY at the clock edge.
- States:
  - IDLE: S_TREADY=1. On accept, acc<=TDATA, op<=TID[1:0], tid<=TID, count<=1. Next state is SEND if TLAST or MAX_OPS==1, else ACCUM.
  - ACCUM: S_TREADY=1. On accept, acc<=f(acc,TDATA), count<=count+1. Next state is SEND if TLAST or count+1==MAX_OPS, else stay. TID of non-first beats is ignored.
  - SEND: S_TREADY=0. M_TVALID=1, M_TDATA=acc, M_TLAST=1, M_TID=tid, M_TDEST=RESULT_DEST. When M_TREADY, next state IDLE. Outputs are held stable while TVALID & !TREADY.
- Operation f:
  - add: acc+x. With SAT_EN, carry out clamps to all-ones.
  - sub: acc-x (first operand minus all later ones). With SAT_EN, borrow clamps to 0.
  - max/min: unsigned compare; saturation does not apply.
  - Computed in TDATAW+1 bits; the result is truncated when wrapping.
- Latency: M_TVALID rises the cycle after the final operand is accepted. Throughput is N+1 cycles per N-operand packet when M_TREADY=1.
- Single-operand packet: the result equals that operand.
- MAX_OPS forced end: the packet closes without TLAST. The next accepted beat starts a new packet with a fresh op/TID, regardless of the previous TLAST.
- count width is clog2(MAX_OPS+1); count never exceeds MAX_OPS.
- No bubble is required between SEND and IDLE. The beat after the handshake cycle is accepted normally.

Test Plan:
1. Add/metadata: TID=0, beats 3, 5(TLAST) -> one result: TDATA=8, TLAST=1, TID=0, TDEST=4'h1; TVALID one cycle after the 2nd accept.
2. Subtract and underflow:
   - TID=1, beats 10, 3, 2(TLAST) -> 5.
   - TID=1, beats 1, 2(TLAST) -> 0xFFFFFFFF with SAT_EN=0, 0x00000000 with SAT_EN=1.
3. Add saturation: TID=0, beats 0xFFFFFFF0, 0x20(TLAST) -> 0x00000010 with SAT_EN=0, 0xFFFFFFFF with SAT_EN=1.
4. Max/min: TID=2, beats 7, 0x80000000, 3(TLAST) -> 0x80000000; same beats with TID=3 -> 3. A later beat carrying TID=0 mid-packet does not change the op.
5. MAX_OPS=4, six beats of value 1 with TLAST only on the 6th:
   - first result is 4 after the 4th beat;
   - second result is 2 with TID taken from the 5th beat;
   - S_TREADY=0 during each SEND.
6. Backpressure and reset:
   - hold M_TREADY=0 for 5 cycles in SEND -> TDATA/TID/TDEST unchanged, S_TREADY=0 throughout.
   - Assert RST_N low mid-ACCUM -> all outputs 0 immediately.
   - After release, packet 2, 2(TLAST) -> 4.

Source files
------------

// File: rtl/axis_reduce_alu.sv
// axis_reduce_alu: reduces a variable-length AXI-Stream operand packet with a
// per-packet operation (add, sub, unsigned max, unsigned min) and emits a
// single-beat result packet toward a fixed NoC destination.
module axis_reduce_alu #(
  parameter int unsigned             TDATAW      = 32,
  parameter int unsigned             TDESTW      = 4,
  parameter int unsigned             TIDW        = 2,
  parameter int unsigned             MAX_OPS     = 8,
  parameter logic [TDESTW-1:0]       RESULT_DEST = TDESTW'(1),
  parameter bit                      SAT_EN      = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TIDW-1:0]   AXIS_S_TID,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TIDW-1:0]   AXIS_M_TID,
  output logic [TDESTW-1:0] AXIS_M_TDEST
);

  localparam int unsigned   CNTW    = $clog2(MAX_OPS + 1);
  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_OPS);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MAX = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  state_t            r_state;
  logic [TDATAW-1:0] r_acc;
  logic [1:0]        r_op;
  logic [TIDW-1:0]   r_tid;
  logic [CNTW-1:0]   r_cnt;
  logic              r_s_tready;
  logic              r_m_tvalid;
  logic [TDATAW-1:0] r_m_tdata;
  logic              r_m_tlast;
  logic [TIDW-1:0]   r_m_tid;
  logic [TDESTW-1:0] r_m_tdest;

  logic              w_accept;
  logic [CNTW-1:0]   w_cnt_nxt;
  logic [TDATAW:0]   w_sum;
  logic [TDATAW:0]   w_dif;
  logic [TDATAW-1:0] w_red;
  logic              w_unused;

  // Destination of incoming operands is irrelevant to the reduction
  assign w_unused  = ^AXIS_S_TDEST;
  assign w_accept  = AXIS_S_TVALID & r_s_tready;
  assign w_cnt_nxt = r_cnt + CNTW'(1);
  assign w_sum     = {1'b0, r_acc} + {1'b0, AXIS_S_TDATA};
  assign w_dif     = {1'b0, r_acc} - {1'b0, AXIS_S_TDATA};

  // Reduction step: combine running accumulator with the incoming operand
  always_comb begin
    w_red = w_sum[TDATAW-1:0];
    case (r_op)
      OP_ADD: begin
        w_red = w_sum[TDATAW-1:0];
        if (SAT_EN && w_sum[TDATAW]) w_red = '1;
      end
      OP_SUB: begin
        w_red = w_dif[TDATAW-1:0];
        if (SAT_EN && w_dif[TDATAW]) w_red = '0;
      end
      OP_MAX:  w_red = (r_acc >= AXIS_S_TDATA) ? r_acc : AXIS_S_TDATA;
      default: w_red = (r_acc <= AXIS_S_TDATA) ? r_acc : AXIS_S_TDATA;
    endcase
  end

  // Packet FSM with registered stream outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_op       <= '0;
      r_tid      <= '0;
      r_cnt      <= '0;
      r_s_tready <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= '0;
      r_m_tdest  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_s_tready <= 1'b1;
          if (w_accept) begin
            r_acc <= AXIS_S_TDATA;
            r_op  <= AXIS_S_TID[1:0];
            r_tid <= AXIS_S_TID;
            r_cnt <= CNTW'(1);
            if (AXIS_S_TLAST || (MAX_OPS == 1)) begin
              r_state    <= S_SEND;
              r_s_tready <= 1'b0;
              r_m_tvalid <= 1'b1;
              r_m_tdata  <= AXIS_S_TDATA;
              r_m_tlast  <= 1'b1;
              r_m_tid    <= AXIS_S_TID;
              r_m_tdest  <= RESULT_DEST;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_red;
            r_cnt <= w_cnt_nxt;
            if (AXIS_S_TLAST || (w_cnt_nxt == MAX_CNT)) begin
              r_state    <= S_SEND;
              r_s_tready <= 1'b0;
              r_m_tvalid <= 1'b1;
              r_m_tdata  <= w_red;
              r_m_tlast  <= 1'b1;
              r_m_tid    <= r_tid;
              r_m_tdest  <= RESULT_DEST;
            end
          end
        end
        S_SEND: begin
          if (AXIS_M_TREADY) begin
            r_state    <= S_IDLE;
            r_s_tready <= 1'b1;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tid    <= '0;
            r_m_tdest  <= '0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_s_tready <= 1'b0;
          r_m_tvalid <= 1'b0;
        end
      endcase
    end
  end

  assign AXIS_S_TREADY = r_s_tready;
  assign AXIS_M_TVALID = r_m_tvalid;
  assign AXIS_M_TDATA  = r_m_tdata;
  assign AXIS_M_TLAST  = r_m_tlast;
  assign AXIS_M_TID    = r_m_tid;
  assign AXIS_M_TDEST  = r_m_tdest;

endmodule

// File: tb/tb_axis_reduce_alu.sv
// Bench for axis_reduce_alu: two instances (wrap and saturate) share stimulus.
module tb_axis_reduce_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic [1:0]  s_tid;
  logic [3:0]  s_dest;
  logic        m_ready;

  logic        a_s_tready, a_m_tvalid, a_m_tlast;
  logic [31:0] a_m_tdata;
  logic [1:0]  a_m_tid;
  logic [3:0]  a_m_tdest;
  logic        b_s_tready, b_m_tvalid, b_m_tlast;
  logic [31:0] b_m_tdata;
  logic [1:0]  b_m_tid;
  logic [3:0]  b_m_tdest;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axis_reduce_alu #(.TDATAW(32), .TDESTW(4), .TIDW(2), .MAX_OPS(4),
                    .RESULT_DEST(4'h1), .SAT_EN(1'b0)) u_wrap (
    .CLK(clk), .RST_N(rst_n),
    .AXIS_S_TVALID(s_valid), .AXIS_S_TREADY(a_s_tready),
    .AXIS_S_TDATA(s_data), .AXIS_S_TLAST(s_last),
    .AXIS_S_TID(s_tid), .AXIS_S_TDEST(s_dest),
    .AXIS_M_TVALID(a_m_tvalid), .AXIS_M_TREADY(m_ready),
    .AXIS_M_TDATA(a_m_tdata), .AXIS_M_TLAST(a_m_tlast),
    .AXIS_M_TID(a_m_tid), .AXIS_M_TDEST(a_m_tdest)
  );

  axis_reduce_alu #(.TDATAW(32), .TDESTW(4), .TIDW(2), .MAX_OPS(4),
                    .RESULT_DEST(4'h1), .SAT_EN(1'b1)) u_sat (
    .CLK(clk), .RST_N(rst_n),
    .AXIS_S_TVALID(s_valid), .AXIS_S_TREADY(b_s_tready),
    .AXIS_S_TDATA(s_data), .AXIS_S_TLAST(s_last),
    .AXIS_S_TID(s_tid), .AXIS_S_TDEST(s_dest),
    .AXIS_M_TVALID(b_m_tvalid), .AXIS_M_TREADY(m_ready),
    .AXIS_M_TDATA(b_m_tdata), .AXIS_M_TLAST(b_m_tlast),
    .AXIS_M_TID(b_m_tid), .AXIS_M_TDEST(b_m_tdest)
  );

  typedef struct {
    logic [1:0]  tid;
    logic [1:0]  mid;
    int          n;
    logic [31:0] d0, d1, d2;
    logic [31:0] e_wrap, e_sat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [1:0] tid, input logic [1:0] mid, input int n,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] e_wrap, input logic [31:0] e_sat);
    vec_t v;
    v.tid = tid; v.mid = mid; v.n = n;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.e_wrap = e_wrap; v.e_sat = e_sat;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one beat starting at a negedge; returns at the negedge after acceptance
  task automatic beat(input logic [31:0] data, input logic last, input logic [1:0] tid);
    int k;
    s_valid = 1'b1; s_data = data; s_last = last; s_tid = tid;
    k = 0;
    while (!a_s_tready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("beat_timeout", 32'd1, 32'd0);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [31:0] e_wrap,
                              input logic [31:0] e_sat, input logic [1:0] tid);
    chk({name, "_a_valid"}, 32'(a_m_tvalid), 32'd1);
    chk({name, "_b_valid"}, 32'(b_m_tvalid), 32'd1);
    chk({name, "_a_data"}, a_m_tdata, e_wrap);
    chk({name, "_b_data"}, b_m_tdata, e_sat);
    chk({name, "_a_last"}, 32'(a_m_tlast), 32'd1);
    chk({name, "_a_tid"}, 32'(a_m_tid), 32'(tid));
    chk({name, "_b_tid"}, 32'(b_m_tid), 32'(tid));
    chk({name, "_a_dest"}, 32'(a_m_tdest), 32'h1);
    chk({name, "_a_sready"}, 32'(a_s_tready), 32'd0);
    chk({name, "_b_sready"}, 32'(b_s_tready), 32'd0);
  endtask

  task automatic check_after_send(input string name);
    chk({name, "_a_valid_low"}, 32'(a_m_tvalid), 32'd0);
    chk({name, "_b_valid_low"}, 32'(b_m_tvalid), 32'd0);
    chk({name, "_a_dest_low"}, 32'(a_m_tdest), 32'd0);
    chk({name, "_a_sready_hi"}, 32'(a_s_tready), 32'd1);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_a_sready"}, 32'(a_s_tready), 32'd0);
    chk({name, "_b_sready"}, 32'(b_s_tready), 32'd0);
    chk({name, "_a_valid"}, 32'(a_m_tvalid), 32'd0);
    chk({name, "_b_valid"}, 32'(b_m_tvalid), 32'd0);
    chk({name, "_a_data"}, a_m_tdata, 32'd0);
    chk({name, "_a_last"}, 32'(a_m_tlast), 32'd0);
    chk({name, "_a_tid"}, 32'(a_m_tid), 32'd0);
    chk({name, "_a_dest"}, 32'(a_m_tdest), 32'd0);
  endtask

  initial begin
    vec_t        v;
    logic [31:0] d;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    s_tid = '0; s_dest = 4'hA; m_ready = 1'b1;

    // Operand packets: first-beat TID, later-beat TID, count, data, wrap/sat results
    add_vec(2'd0, 2'd0, 2, 32'd3, 32'd5, 32'd0, 32'd8, 32'd8);
    add_vec(2'd1, 2'd1, 3, 32'd10, 32'd3, 32'd2, 32'd5, 32'd5);
    add_vec(2'd1, 2'd1, 2, 32'd1, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'h0);
    add_vec(2'd0, 2'd0, 2, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'h10, 32'hFFFF_FFFF);
    add_vec(2'd2, 2'd0, 3, 32'd7, 32'h8000_0000, 32'd3, 32'h8000_0000, 32'h8000_0000);
    add_vec(2'd3, 2'd0, 3, 32'd7, 32'h8000_0000, 32'd3, 32'd3, 32'd3);
    add_vec(2'd2, 2'd2, 1, 32'h1234, 32'd0, 32'd0, 32'h1234, 32'h1234);
    add_vec(2'd0, 2'd0, 2, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    add_vec(2'd1, 2'd1, 2, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0);
    add_vec(2'd3, 2'd1, 2, 32'd9, 32'd2, 32'd0, 32'd2, 32'd2);

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven packets, each followed by the result handshake
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      for (int j = 0; j < v.n; j++) begin
        d = (j == 0) ? v.d0 : ((j == 1) ? v.d1 : v.d2);
        beat(d, (j == v.n - 1), (j == 0) ? v.tid : v.mid);
      end
      check_result($sformatf("vec%0d", i), v.e_wrap, v.e_sat, v.tid);
      @(negedge clk);
      check_after_send($sformatf("vec%0d", i));
    end

    // Forced end at MAX_OPS=4 without TLAST, then a fresh packet
    beat(32'd1, 1'b0, 2'd0);
    beat(32'd1, 1'b0, 2'd3);
    beat(32'd1, 1'b0, 2'd3);
    beat(32'd1, 1'b0, 2'd3);
    check_result("maxops1", 32'd4, 32'd4, 2'd0);
    beat(32'd1, 1'b0, 2'd0);
    beat(32'd1, 1'b1, 2'd2);
    check_result("maxops2", 32'd2, 32'd2, 2'd0);
    @(negedge clk);
    check_after_send("maxops2");

    // Backpressure: result held stable while downstream stalls
    m_ready = 1'b0;
    beat(32'd9, 1'b0, 2'd1);
    beat(32'd4, 1'b1, 2'd2);
    for (int c = 0; c < 5; c++) begin
      check_result($sformatf("stall%0d", c), 32'd5, 32'd5, 2'd1);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check_after_send("stall_end");

    // Reset mid-accumulation discards the partial packet
    beat(32'd7, 1'b0, 2'd0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(32'd2, 1'b0, 2'd0);
    beat(32'd2, 1'b1, 2'd0);
    check_result("postrst", 32'd4, 32'd4, 2'd0);
    @(negedge clk);
    check_after_send("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
